arquitetura_uart_onchip_ram_pipe: RTL and testbench

Parametrised successor of the system's single-port on-chip RAM Avalon-MM slave.
- Same role: Nios program/data memory on the UART architecture bus, byte-enabled 32-bit default.
- Adds configurable width, depth and read latency (1..3), an explicit read strobe and a readdatavalid pipeline.
- Adds out-of-range detection for non-power-of-two depths, and an inferred array instead of a vendor megafunction.

---
 rtl/arquitetura_uart_mem_pkg.sv | 26 ++
 rtl/arquitetura_uart_ram_core.sv | 40 ++++
 rtl/arquitetura_uart_onchip_ram_pipe.sv | 105 ++++++++++
 tb/tb_arquitetura_uart_onchip_ram_pipe.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arquitetura_uart_mem_pkg.sv
// Shared constants and elaboration checks for the
// UART-architecture on-chip RAM slave.
package arquitetura_uart_mem_pkg;

  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_DEPTH        = 5320;
  localparam int DEF_ADDR_WIDTH   = 13;
  localparam int DEF_READ_LATENCY = 1;

  function automatic int lane_count(int dw);
    return dw / 8;
  endfunction

  function automatic bit latency_ok(int lat);
    return (lat >= 1) && (lat <= 3);
  endfunction

  function automatic bit depth_ok(int depth, int aw);
    return (depth >= 1) && (longint'(depth) <= (longint'(1) << aw));
  endfunction

  function automatic bit width_ok(int dw);
    return (dw >= 8) && ((dw % 8) == 0);
  endfunction

endpackage

// File: rtl/arquitetura_uart_ram_core.sv
// Inferred single-port byte-enabled RAM with registered,
// read-before-write output.
module arquitetura_uart_ram_core
  import arquitetura_uart_mem_pkg::*;
#(
  parameter int    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int    DEPTH      = DEF_DEPTH,
  parameter int    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter string INIT_FILE  = ""
) (
  input  logic                              clk,
  input  logic                              we_i,
  input  logic                              re_i,
  input  logic [ADDR_WIDTH-1:0]             addr_i,
  input  logic [lane_count(DATA_WIDTH)-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]             wdata_i,
  output logic [DATA_WIDTH-1:0]             rdata_o
);

  localparam int NB = lane_count(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < NB; i++) begin
        if (be_i[i]) begin
          mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
    if (re_i) begin
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/arquitetura_uart_onchip_ram_pipe.sv
// Avalon-MM on-chip RAM slave with configurable read latency,
// readdatavalid pipeline and sticky out-of-range flag.
module arquitetura_uart_onchip_ram_pipe
  import arquitetura_uart_mem_pkg::*;
#(
  parameter int    DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int    DEPTH        = DEF_DEPTH,
  parameter int    ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int    READ_LATENCY = DEF_READ_LATENCY,
  parameter string INIT_FILE    = "arquiteturaUart_onchip_memory2_0.hex"
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [ADDR_WIDTH-1:0]             address,
  input  logic [lane_count(DATA_WIDTH)-1:0] byteenable,
  input  logic                              chipselect,
  input  logic                              read,
  input  logic                              write,
  input  logic [DATA_WIDTH-1:0]             writedata,
  input  logic                              clken,
  input  logic                              reset_req,
  output logic [DATA_WIDTH-1:0]             readdata,
  output logic                              readdatavalid,
  output logic                              oor_error
);

  localparam int LAT = READ_LATENCY;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  if (!latency_ok(READ_LATENCY)) begin : g_bad_lat
    $error("READ_LATENCY must be 1, 2 or 3");
  end
  if (!depth_ok(DEPTH, ADDR_WIDTH)) begin : g_bad_depth
    $error("DEPTH must fit in 2**ADDR_WIDTH");
  end
  if (!width_ok(DATA_WIDTH)) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8");
  end

  logic                  en;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  oor;
  logic [DATA_WIDTH-1:0] core_rdata;
  logic [DATA_WIDTH-1:0] d1_q;
  logic [DATA_WIDTH-1:0] d2_q;
  logic [DATA_WIDTH-1:0] tail;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic [DATA_WIDTH-1:0] last_q;
  logic [LAT-1:0]        vld_q;
  logic [LAT-1:0]        zero_q;
  logic                  oor_q;

  assign en     = clken & ~reset_req;
  assign wr_acc = chipselect & write & en;
  assign rd_acc = chipselect & read & en & ~write;
  assign oor    = ({1'b0, address} >= DEPTH_C);

  arquitetura_uart_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_core (
    .clk     (clk),
    .we_i    (wr_acc & ~oor),
    .re_i    (rd_acc),
    .addr_i  (address),
    .be_i    (byteenable),
    .wdata_i (writedata),
    .rdata_o (core_rdata)
  );

  // Core output register is stage one; d1/d2 add the extra latency.
  assign tail   = (LAT == 1) ? core_rdata :
                  (LAT == 2) ? d1_q : d2_q;
  assign rd_mux = zero_q[LAT-1] ? '0 : tail;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= '0;
      zero_q <= '0;
      d1_q   <= '0;
      d2_q   <= '0;
      last_q <= '0;
      oor_q  <= 1'b0;
    end else if (en) begin
      vld_q  <= (vld_q << 1) | LAT'(rd_acc);
      zero_q <= (zero_q << 1) | LAT'(rd_acc & oor);
      d1_q   <= core_rdata;
      d2_q   <= d1_q;
      if (vld_q[LAT-1]) begin
        last_q <= rd_mux;
      end
      if ((wr_acc | rd_acc) & oor) begin
        oor_q <= 1'b1;
      end
    end
  end

  assign readdatavalid = vld_q[LAT-1];
  assign readdata      = vld_q[LAT-1] ? rd_mux : last_q;
  assign oor_error     = oor_q;

endmodule

// File: tb/tb_arquitetura_uart_onchip_ram_pipe.sv
// Randomised bench: three instances (latency 1..3) share stimulus
// and are compared against a transaction-level memory model.
module tb_arquitetura_uart_onchip_ram_pipe;

  localparam int DW = 32;
  localparam int AW = 13;
  localparam int DEPTH = 5320;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] address = '0;
  logic [3:0]    byteenable = '0;
  logic          chipselect = 1'b0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [DW-1:0] writedata = '0;
  logic          clken = 1'b1;
  logic          reset_req = 1'b0;
  logic [2:0]    rv;
  logic [2:0]    oor;
  logic [DW-1:0] rdat [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    arquitetura_uart_onchip_ram_pipe #(
      .DATA_WIDTH   (DW),
      .DEPTH        (DEPTH),
      .ADDR_WIDTH   (AW),
      .READ_LATENCY (g + 1),
      .INIT_FILE    ("")
    ) u_dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .address       (address),
      .byteenable    (byteenable),
      .chipselect    (chipselect),
      .read          (read),
      .write         (write),
      .writedata     (writedata),
      .clken         (clken),
      .reset_req     (reset_req),
      .readdata      (rdat[g]),
      .readdatavalid (rv[g]),
      .oor_error     (oor[g])
    );
  end

  // Reference model: every accepted read is logged with the enabled-edge
  // count at which it was accepted; latency L shows it L-1 enabled edges later.
  typedef struct {
    logic [31:0] d;
    bit          chk;
    int          acc;
  } rd_t;

  rd_t         rq [$];
  int          head [3];
  bit          sh_v [3];
  bit          sh_c [3];
  logic [31:0] sh_d [3];
  bit          oor_m;
  int          encnt;
  logic [31:0] mem_m [int];

  task automatic model_reset();
    rq.delete();
    for (int l = 0; l < 3; l++) begin
      head[l] = 0;
      sh_v[l] = 1'b0;
      sh_c[l] = 1'b0;
      sh_d[l] = '0;
    end
    oor_m = 1'b0;
    encnt = 0;
  endtask

  task automatic drive(bit cs, bit rd, bit wr, int a,
                       logic [31:0] d, logic [3:0] be, bit ce);
    chipselect = cs;
    read       = rd;
    write      = wr;
    address    = AW'(a);
    writedata  = d;
    byteenable = be;
    clken      = ce;
    reset_req  = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 0, '0, '0, 1'b1);
  endtask

  task automatic step();
    int          a;
    logic [31:0] v;
    rd_t         r;
    @(posedge clk);
    a = int'(address);
    if (reset_n && clken && !reset_req) begin
      encnt++;
      if (chipselect && write) begin
        if (a >= DEPTH) oor_m = 1'b1;
        else if (mem_m.exists(a) || byteenable == 4'hF) begin
          v = mem_m.exists(a) ? mem_m[a] : '0;
          for (int i = 0; i < 4; i++)
            if (byteenable[i]) v[8*i +: 8] = writedata[8*i +: 8];
          mem_m[a] = v;
        end
      end else if (chipselect && read) begin
        r.acc = encnt;
        if (a >= DEPTH) begin
          oor_m = 1'b1;
          r.d = '0;
          r.chk = 1'b1;
        end else if (mem_m.exists(a)) begin
          r.d = mem_m[a];
          r.chk = 1'b1;
        end else begin
          r.d = '0;
          r.chk = 1'b0;
        end
        rq.push_back(r);
      end
      for (int l = 0; l < 3; l++) begin
        if (head[l] < rq.size() && rq[head[l]].acc + l == encnt) begin
          sh_v[l] = 1'b1;
          sh_d[l] = rq[head[l]].d;
          sh_c[l] = rq[head[l]].chk;
          head[l]++;
        end else begin
          sh_v[l] = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    idle();
    repeat (2) @(posedge clk);
    #1;
    for (int l = 0; l < 3; l++) begin
      checks++;
      if (rv[l] !== 1'b0) begin
        errors++;
        $display("FAIL reset_valid lat%0d: got %b want 0", l + 1, rv[l]);
      end
      checks++;
      if (oor[l] !== 1'b0) begin
        errors++;
        $display("FAIL reset_oor lat%0d: got %b want 0", l + 1, oor[l]);
      end
      checks++;
      if (rdat[l] !== 32'h0) begin
        errors++;
        $display("FAIL reset_data lat%0d: got %h want 0", l + 1, rdat[l]);
      end
    end
    #3 reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    for (int c = 0; c < 10; c++) begin
      case (c)
        0: drive(1, 0, 1, 5, 32'hDEADBEEF, 4'hF, 1);
        1: drive(1, 1, 0, 5, '0, '0, 1);
        2: drive(1, 0, 1, 7, 32'h11223344, 4'hF, 1);
        3: drive(1, 0, 1, 7, 32'hAABBCCDD, 4'h5, 1);
        4: drive(1, 1, 0, 7, '0, '0, 1);
        default: idle();
      endcase
      step();
      for (int l = 0; l < 3; l++) begin
        checks++;
        if (rv[l] !== sh_v[l]) begin
          errors++;
          $display("FAIL wr_rd_valid lat%0d c%0d: got %b want %b", l + 1, c, rv[l], sh_v[l]);
        end
        if (sh_v[l] && sh_c[l]) begin
          checks++;
          if (rdat[l] !== sh_d[l]) begin
            errors++;
            $display("FAIL wr_rd_data lat%0d c%0d: got %h want %h", l + 1, c, rdat[l], sh_d[l]);
          end
        end
      end
    end
  endtask

  task automatic test_clken_stall();
    for (int c = 0; c < 14; c++) begin
      case (c)
        0, 1, 2: drive(1, 0, 1, c, $urandom, 4'hF, 1);
        3: drive(1, 1, 0, 0, '0, '0, 1);
        4: drive(1, 1, 0, 1, '0, '0, 1);
        5, 6: drive(1, 1, 0, 2, '0, '0, 0);
        7: drive(1, 1, 0, 2, '0, '0, 1);
        9, 10: drive(0, 0, 0, 0, '0, '0, 0);
        default: idle();
      endcase
      step();
      for (int l = 0; l < 3; l++) begin
        checks++;
        if (rv[l] !== sh_v[l]) begin
          errors++;
          $display("FAIL stall_valid lat%0d c%0d: got %b want %b", l + 1, c, rv[l], sh_v[l]);
        end
        if (sh_v[l] && sh_c[l]) begin
          checks++;
          if (rdat[l] !== sh_d[l]) begin
            errors++;
            $display("FAIL stall_data lat%0d c%0d: got %h want %h", l + 1, c, rdat[l], sh_d[l]);
          end
        end
      end
    end
  endtask

  task automatic test_oor();
    for (int c = 0; c < 9; c++) begin
      case (c)
        0: drive(1, 0, 1, DEPTH - 1, $urandom, 4'hF, 1);
        1: drive(1, 0, 1, DEPTH, 32'h12345678, 4'hF, 1);
        2: drive(1, 1, 0, DEPTH, '0, '0, 1);
        3: drive(1, 1, 0, DEPTH - 1, '0, '0, 1);
        default: idle();
      endcase
      step();
      for (int l = 0; l < 3; l++) begin
        checks++;
        if (rv[l] !== sh_v[l] || oor[l] !== oor_m) begin
          errors++;
          $display("FAIL oor_flags lat%0d c%0d: got v%b o%b want v%b o%b", l + 1, c, rv[l], oor[l], sh_v[l], oor_m);
        end
        if (sh_v[l] && sh_c[l]) begin
          checks++;
          if (rdat[l] !== sh_d[l]) begin
            errors++;
            $display("FAIL oor_data lat%0d c%0d: got %h want %h", l + 1, c, rdat[l], sh_d[l]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    drive(1, 1, 0, 5, '0, '0, 1);
    step();
    idle();
    #2 reset_n = 1'b0;
    #1;
    for (int l = 0; l < 3; l++) begin
      checks++;
      if (rv[l] !== 1'b0 || oor[l] !== 1'b0) begin
        errors++;
        $display("FAIL rst_async lat%0d: got v%b o%b want v0 o0", l + 1, rv[l], oor[l]);
      end
    end
    model_reset();
    step();
    step();
    #3 reset_n = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c == 4) drive(1, 1, 0, 5, '0, '0, 1);
      else idle();
      step();
      for (int l = 0; l < 3; l++) begin
        checks++;
        if (rv[l] !== sh_v[l] || oor[l] !== oor_m) begin
          errors++;
          $display("FAIL rst_mid_flags lat%0d c%0d: got v%b o%b want v%b o%b", l + 1, c, rv[l], oor[l], sh_v[l], oor_m);
        end
        if (sh_v[l] && sh_c[l]) begin
          checks++;
          if (rdat[l] !== sh_d[l]) begin
            errors++;
            $display("FAIL rst_mid_data lat%0d c%0d: got %h want %h", l + 1, c, rdat[l], sh_d[l]);
          end
        end
      end
    end
  endtask

  task automatic test_simul_rw();
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: drive(1, 1, 1, 9, 32'hCAFEF00D, 4'hF, 1);
        3: drive(1, 1, 0, 9, '0, '0, 1);
        default: idle();
      endcase
      step();
      for (int l = 0; l < 3; l++) begin
        checks++;
        if (rv[l] !== sh_v[l]) begin
          errors++;
          $display("FAIL simul_valid lat%0d c%0d: got %b want %b", l + 1, c, rv[l], sh_v[l]);
        end
        if (sh_v[l] && sh_c[l]) begin
          checks++;
          if (rdat[l] !== sh_d[l]) begin
            errors++;
            $display("FAIL simul_data lat%0d c%0d: got %h want %h", l + 1, c, rdat[l], sh_d[l]);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 16; c++) begin
      if (c < 6) drive(1, 0, 1, 20 + c, $urandom, 4'hF, 1);
      else if (c < 12) drive(1, 1, 0, 14 + c, '0, '0, 1);
      else idle();
      step();
      for (int l = 0; l < 3; l++) begin
        checks++;
        if (rv[l] !== sh_v[l]) begin
          errors++;
          $display("FAIL b2b_valid lat%0d c%0d: got %b want %b", l + 1, c, rv[l], sh_v[l]);
        end
        if (sh_v[l] && sh_c[l]) begin
          checks++;
          if (rdat[l] !== sh_d[l]) begin
            errors++;
            $display("FAIL b2b_data lat%0d c%0d: got %h want %h", l + 1, c, rdat[l], sh_d[l]);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int a;
    for (int c = 0; c < 400; c++) begin
      a = ($urandom_range(0, 15) == 0) ? DEPTH + $urandom_range(0, 2871)
                                       : $urandom_range(0, 15);
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) == 0, a, $urandom, 4'($urandom),
            $urandom_range(0, 7) != 0);
      reset_req = ($urandom_range(0, 15) == 0);
      step();
      for (int l = 0; l < 3; l++) begin
        checks++;
        if (rv[l] !== sh_v[l] || oor[l] !== oor_m) begin
          errors++;
          $display("FAIL rand_flags lat%0d c%0d: got v%b o%b want v%b o%b", l + 1, c, rv[l], oor[l], sh_v[l], oor_m);
        end
        if (sh_v[l] && sh_c[l]) begin
          checks++;
          if (rdat[l] !== sh_d[l]) begin
            errors++;
            $display("FAIL rand_data lat%0d c%0d: got %h want %h", l + 1, c, rdat[l], sh_d[l]);
          end
        end
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_clken_stall();
    test_oor();
    test_reset_mid_read();
    test_simul_rw();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
